// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the fetch stage.
//   INSTR_WIDTH   - instruction word width
//   ADDR_WIDTH    - program-counter / byte-address width
//   PC_STEP       - sequential PC increment
//   fetch_state_t - fetch FSM states (FETCH, FAULT)
//   pc_is_legal   - word-aligned and inside the implemented address space
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // A PC is fetchable when it is word aligned and every bit above the
    // implemented byte-address range is zero.
    function automatic logic pc_is_legal(input logic [ADDR_WIDTH-1:0] pc,
                                         input int mem_addr_bits);
        logic [ADDR_WIDTH-1:0] w_high;
        w_high = pc >> mem_addr_bits;
        return (pc[1:0] == 2'b00) && (w_high == '0);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding {pc, instruction} pairs between fetch and decode.
// The head is read straight out of the storage registers, so the output is
// stable while it waits to be accepted.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   i_push     - write i_data at the tail (ignored when full without a pop)
//   i_pop      - retire the head (ignored when empty)
//   i_flush    - discard all entries; wins over push and pop
//   i_data     - payload to write
//   o_valid    - FIFO holds at least one entry
//   o_full     - FIFO holds DEPTH entries
//   o_data     - head payload
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic w_pop;
    logic w_push;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == FULL_COUNT);
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && o_valid;
    // Full is still writable when the head leaves in the same cycle.
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Fetch stage: owns the PC, reads the combinational instruction port, and
// queues {pc, instruction} pairs for decode. Handles redirects and flags
// fetch faults on misaligned or out-of-range PCs.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   imem_pc           - PC presented to the instruction memory
//   imem_instruction  - combinational word returned for imem_pc
//   redirect_valid/pc - single-cycle redirect from execute
//   out_valid/ready   - decode handshake
//   out_pc/out_instr  - head entry payload
//   fetch_fault       - sticky fault flag
//   fault_pc          - PC that raised the fault
//   dbg_state         - current fetch FSM state
//
// Handshake: an entry transfers on a rising edge where out_valid && out_ready.
// out_valid never depends on out_ready, and out_pc/out_instr hold while
// out_valid is high and out_ready is low. out_ready with out_valid low has no
// effect.
// ---------------------------------------------------------------------------
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC      = 32'h0000_0000,
    parameter int                    QUEUE_DEPTH   = 2,
    parameter int                    MEM_ADDR_BITS = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDR_WIDTH-1:0]  imem_pc,
    input  logic [INSTR_WIDTH-1:0] imem_instruction,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic                   fetch_fault,
    output logic [ADDR_WIDTH-1:0]  fault_pc,
    output fetch_state_t           dbg_state
);

    fetch_state_t                        r_state;
    logic [ADDR_WIDTH-1:0]               r_pc;
    logic                                r_fault;
    logic [ADDR_WIDTH-1:0]               r_fault_pc;

    logic                                w_pc_legal;
    logic                                w_pop;
    logic                                w_push;
    logic                                w_fifo_valid;
    logic                                w_fifo_full;
    logic [ADDR_WIDTH+INSTR_WIDTH-1:0]   w_head;

    assign w_pc_legal = pc_is_legal(r_pc, MEM_ADDR_BITS);
    assign w_pop      = w_fifo_valid && out_ready;
    // A redirect discards the queue, so nothing fetched in that cycle may land.
    assign w_push     = !redirect_valid && (r_state == FETCH) && w_pc_legal &&
                        (!w_fifo_full || w_pop);

    fetch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .W     (ADDR_WIDTH + INSTR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  ({r_pc, imem_instruction}),
        .o_valid (w_fifo_valid),
        .o_full  (w_fifo_full),
        .o_data  (w_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else if (redirect_valid) begin
            // Always resume fetching at the target; an illegal target is
            // caught by the normal check next cycle so fault_pc records it.
            r_pc    <= redirect_pc;
            r_state <= FETCH;
            if (pc_is_legal(redirect_pc, MEM_ADDR_BITS)) begin
                r_fault <= 1'b0;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (!w_pc_legal) begin
                        r_state    <= FAULT;
                        r_fault    <= 1'b1;
                        r_fault_pc <= r_pc;
                    end else if (w_push) begin
                        // Unmasked add: stepping past the top of memory
                        // produces an out-of-range PC that faults next cycle.
                        r_pc <= r_pc + PC_STEP;
                    end
                end
                FAULT: begin
                    r_pc <= r_pc;
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    assign imem_pc     = r_pc;
    assign out_valid   = w_fifo_valid;
    assign out_pc      = w_head[ADDR_WIDTH+INSTR_WIDTH-1:INSTR_WIDTH];
    assign out_instr   = w_head[INSTR_WIDTH-1:0];
    assign fetch_fault = r_fault;
    assign fault_pc    = r_fault_pc;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
    import cpu_pkg::*;

    localparam int          DEPTH    = 2;
    localparam int          MAB      = 14;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    fetch_state_t dbg_state;

    instr_fetch_queue #(
        .RESET_PC      (RST_PC),
        .QUEUE_DEPTH   (DEPTH),
        .MEM_ADDR_BITS (MAB)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instr        (out_instr),
        .fetch_fault      (fetch_fault),
        .fault_pc         (fault_pc),
        .dbg_state        (dbg_state)
    );

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_instruction = mem_word(imem_pc);

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> MAB) == 32'd0);
    endfunction

    // ---------------- scoreboard / reference model ----------------
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_fault_pc;
    bit          m_fault;
    bit          m_faulting;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc       = RST_PC;
        m_fault    = 0;
        m_faulting = 0;
        m_fault_pc = 32'h0;
    endtask

    // One rising edge of the fetch stage, from the rules: decode takes the
    // head if it wants it, a redirect wipes the queue and moves the PC,
    // otherwise a legal PC is fetched into any free slot and an illegal one
    // stops fetching with a sticky fault.
    task automatic model_edge();
        if ((exp_q.size() > 0) && out_ready) void'(exp_q.pop_front());
        if (redirect_valid) begin
            exp_q.delete();
            m_pc       = redirect_pc;
            m_faulting = 0;
            if (legal(redirect_pc)) m_fault = 0;
        end else if (!m_faulting) begin
            if (!legal(m_pc)) begin
                m_faulting = 1;
                m_fault    = 1;
                m_fault_pc = m_pc;
            end else if (exp_q.size() < DEPTH) begin
                exp_q.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [63:0] head;
        check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            check_eq("out_pc", out_pc, head[63:32]);
            check_eq("out_instr", out_instr, head[31:0]);
        end
        check_eq("imem_pc", imem_pc, m_pc);
        check_eq("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        if (m_fault) check_eq("fault_pc", fault_pc, m_fault_pc);
        check_eq("state_fault", 32'(dbg_state == FAULT), 32'(m_faulting));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 4))
            0: t = 32'($urandom_range(0, 4095)) << 2;
            1: t = 32'h3FF0 + (32'($urandom_range(0, 3)) << 2);
            2: t = (32'($urandom_range(0, 4095)) << 2) | 32'($urandom_range(1, 3));
            3: t = 32'h4000 + (32'($urandom_range(0, 255)) << 2);
            default: t = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
        endcase
        return t;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #12;
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_out_pc", out_pc, 32'h0);
        check_eq("rst_out_instr", out_instr, 32'h0);
        check_eq("rst_imem_pc", imem_pc, RST_PC);
        check_eq("rst_fetch_fault", 32'(fetch_fault), 32'h0);
        check_eq("rst_fault_pc", fault_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming after reset release.
        out_ready = 1'b1;
        repeat (3) step();

        // Back-pressure: queue fills and the head holds.
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        repeat (4) step();

        // Redirect while full.
        out_ready = 1'b0;
        repeat (3) step();
        do_redirect(32'h100);
        repeat (2) step();

        // Misaligned redirect faults, a legal one clears the fault.
        out_ready = 1'b1;
        do_redirect(32'h102);
        repeat (3) step();
        do_redirect(32'h200);
        repeat (2) step();

        // Walking off the top of memory.
        do_redirect(32'h3FF0);
        repeat (8) step();

        // Same with decode stalled: entries ahead of the fault drain later.
        out_ready = 1'b0;
        do_redirect(32'h3FF4);
        repeat (4) step();
        out_ready = 1'b1;
        repeat (3) step();

        // Out-of-range redirect while already faulted.
        do_redirect(32'h0001_0000);
        repeat (2) step();
        do_redirect(32'h40);
        repeat (2) step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                do_redirect(rand_target());
            end else begin
                step();
            end
        end

        // Asynchronous reset with a full queue and a pending fault.
        out_ready = 1'b0;
        do_redirect(32'h3FF8);
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_out_valid", 32'(out_valid), 32'h0);
        check_eq("async_imem_pc", imem_pc, RST_PC);
        check_eq("async_fetch_fault", 32'(fetch_fault), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
